draw_ball: RTL and testbench

DRAW_BALL -- requirements
Module: draw_ball

---
 rtl/pong_pkg.sv | 20 ++
 rtl/ball_ctl.sv | 177 +++++++++++++++++
 rtl/draw_ball.sv | 123 ++++++++++++
 tb/tb_draw_ball.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong video blocks.
//   - Screen geometry of the active area
//   - Ball rest position (screen centre for a 16-pixel ball)
//   - Encoding of the ball motion FSM states
package pong_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  // Top-left corner that centres a 16x16 ball on the 1024x768 screen.
  localparam logic [10:0] BALL_X0 = 11'd504;
  localparam logic [10:0] BALL_Y0 = 11'd376;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2
  } ball_state_e;

endpackage

// File: rtl/ball_ctl.sv
// Ball motion controller: FSM, position registers and direction bits.
// All motion happens only in cycles where tick=1 (one per frame).
// Ports:
//   pclk, rst                - pixel clock, synchronous active-high reset
//   tick                     - frame tick from the vblank edge detector
//   serve                    - starts play when high at a tick in IDLE
//   paddle_l_y, paddle_r_y   - paddle top edges, used only at a tick
//   ball_x, ball_y           - ball top-left position
//   miss_l, miss_r           - one-cycle pulse when the ball exits left/right
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ball parked at screen centre, waiting for serve at a tick
// PLAY    | ball moves SPEED px per axis per tick, bounces off walls/paddles
// MISS    | ball frozen at the exit edge for MISS_FRAMES ticks
module ball_ctl
  import pong_pkg::*;
#(
  parameter int BALL_SIZE   = 16,
  parameter int SPEED       = 4,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_XL   = 32,
  parameter int PADDLE_XR   = 976,
  parameter int MISS_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        serve,
  input  logic [10:0] paddle_l_y,
  input  logic [10:0] paddle_r_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        miss_l,
  output logic        miss_r
);

  localparam int CNT_W = $clog2(MISS_FRAMES + 1);

  // Comparisons are done in 12 bits so that sums near the screen edge
  // never wrap.
  localparam logic [11:0] SPD    = 12'(SPEED);
  localparam logic [11:0] BS     = 12'(BALL_SIZE);
  localparam logic [11:0] PH     = 12'(PADDLE_H);
  localparam logic [11:0] PXL    = 12'(PADDLE_XL);
  localparam logic [11:0] PXR    = 12'(PADDLE_XR);
  localparam logic [11:0] L_FACE = 12'(PADDLE_XL + PADDLE_W);
  localparam logic [11:0] R_EDGE = 12'(PADDLE_XR + PADDLE_W);
  localparam logic [11:0] R_STOP = 12'(PADDLE_XR - BALL_SIZE);
  localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_FRAMES - 1);

  ball_state_e      state_q, state_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_l_q, miss_l_d, miss_r_q, miss_r_d;

  logic [11:0] x12, y12, pl12, pr12;
  logic        hit_l, hit_r;

  assign x12  = {1'b0, x_q};
  assign y12  = {1'b0, y_q};
  assign pl12 = {1'b0, paddle_l_y};
  assign pr12 = {1'b0, paddle_r_y};

  // x > PXL guards the subtraction, so a wrapped x12-SPD never matters.
  assign hit_l = (x12 - SPD <= L_FACE) && (x12 > PXL) &&
                 (y12 + BS > pl12) && (y12 < pl12 + PH);
  assign hit_r = (x12 + BS + SPD >= PXR) && (x12 + BS < R_EDGE) &&
                 (y12 + BS > pr12) && (y12 < pr12 + PH);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          x_d = BALL_X0;
          y_d = BALL_Y0;
          if (serve) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (dy_q) begin
            if (y12 + SPD >= Y_MAX) begin
              y_d  = 11'(Y_MAX);
              dy_d = 1'b0;
            end else begin
              y_d = 11'(y12 + SPD);
            end
          end else begin
            if (y12 <= SPD) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else begin
              y_d = 11'(y12 - SPD);
            end
          end

          if (!dx_q) begin
            if (hit_l) begin
              x_d  = 11'(L_FACE);
              dx_d = 1'b1;
            end else if (x12 <= SPD) begin
              x_d      = '0;
              miss_l_d = 1'b1;
              state_d  = ST_MISS;
              cnt_d    = CNT_LOAD;
            end else begin
              x_d = 11'(x12 - SPD);
            end
          end else begin
            if (hit_r) begin
              x_d  = 11'(R_STOP);
              dx_d = 1'b0;
            end else if (x12 >= X_MAX - SPD) begin
              x_d      = 11'(X_MAX);
              miss_r_d = 1'b1;
              state_d  = ST_MISS;
              cnt_d    = CNT_LOAD;
            end else begin
              x_d = 11'(x12 + SPD);
            end
          end
        end
        ST_MISS: begin
          // dx is left untouched through MISS, so it still points at the
          // side that missed when IDLE is re-entered.
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            x_d     = BALL_X0;
            y_d     = BALL_Y0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= BALL_X0;
      y_q      <= BALL_Y0;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      cnt_q    <= '0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign miss_l = miss_l_q;
  assign miss_r = miss_r_q;

endmodule

// File: rtl/draw_ball.sv
// Ball overlay stage of the pong video pipeline.
// Delays the raster timing by one pclk, paints the ball over rgb_in and
// derives the per-frame tick from the rising edge of vblnk_in.
// Ports:
//   pclk, rst                         - pixel clock, sync active-high reset
//   hcount_in..vblnk_in, rgb_in       - raster from the background stage
//   paddle_l_y, paddle_r_y, serve     - game inputs, used at the frame tick
//   hcount_out..vblnk_out, rgb_out    - raster delayed by one pclk
//   ball_x, ball_y                    - ball top-left position
//   miss_l, miss_r                    - one-cycle miss pulses
module draw_ball
  import pong_pkg::*;
#(
  parameter int          BALL_SIZE   = 16,
  parameter int          SPEED       = 4,
  parameter logic [11:0] BALL_COLOR  = 12'hFFF,
  parameter int          PADDLE_H    = 64,
  parameter int          PADDLE_W    = 16,
  parameter int          PADDLE_XL   = 32,
  parameter int          PADDLE_XR   = 976,
  parameter int          MISS_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] paddle_l_y,
  input  logic [10:0] paddle_r_y,
  input  logic        serve,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        miss_l,
  output logic        miss_r
);

  localparam logic [11:0] BS = 12'(BALL_SIZE);

  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic [11:0] rgb_q, rgb_d;
  logic        in_ball, tick;

  // vblnk_q doubles as the vblank history for edge detection.
  assign tick = vblnk_in & ~vblnk_q;

  always_comb begin
    hcount_d = hcount_in;
    vcount_d = vcount_in;
    hsync_d  = hsync_in;
    vsync_d  = vsync_in;
    hblnk_d  = hblnk_in;
    vblnk_d  = vblnk_in;
    in_ball  = !hblnk_in && !vblnk_in &&
               ({1'b0, hcount_in} >= {1'b0, ball_x}) &&
               ({1'b0, hcount_in} <  {1'b0, ball_x} + BS) &&
               ({1'b0, vcount_in} >= {1'b0, ball_y}) &&
               ({1'b0, vcount_in} <  {1'b0, ball_y} + BS);
    rgb_d    = in_ball ? BALL_COLOR : rgb_in;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      rgb_q    <= rgb_d;
    end
  end

  ball_ctl #(
    .BALL_SIZE  (BALL_SIZE),
    .SPEED      (SPEED),
    .PADDLE_H   (PADDLE_H),
    .PADDLE_W   (PADDLE_W),
    .PADDLE_XL  (PADDLE_XL),
    .PADDLE_XR  (PADDLE_XR),
    .MISS_FRAMES(MISS_FRAMES)
  ) u_ball_ctl (
    .pclk      (pclk),
    .rst       (rst),
    .tick      (tick),
    .serve     (serve),
    .paddle_l_y(paddle_l_y),
    .paddle_r_y(paddle_r_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .miss_l    (miss_l),
    .miss_r    (miss_r)
  );

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_ball.sv
// Randomized bench for draw_ball against a frame-level game model.
// Frames are compressed to a handful of pclk cycles; the raster inputs
// are random coordinates scattered around the ball.
module tb_draw_ball;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, paddle_l_y, paddle_r_y;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, serve;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out, ball_x, ball_y;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, miss_l, miss_r;
  logic [11:0] rgb_out;

  always #5 pclk = ~pclk;

  draw_ball dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .serve(serve),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .ball_x(ball_x), .ball_y(ball_y),
    .miss_l(miss_l), .miss_r(miss_r)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Game model: mode 0 waiting, 1 in play, 2 frozen after a miss.
  int m_mode, m_x, m_y, m_dx, m_dy, m_left, m_vprev;
  int m_lhits = 0, m_misses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int trk(input int y);
    return (y < 10) ? 0 : y - 10;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 504; m_y = 376; m_dx = 1; m_dy = 1; m_left = 0; m_vprev = 0;
  endtask

  task automatic model_tick(input int srv, input int pl, input int pr,
                            output int ml, output int mr);
    int nx, ny;
    ml = 0; mr = 0;
    if (m_mode == 0) begin
      m_x = 504; m_y = 376;
      if (srv != 0) m_mode = 1;
    end else if (m_mode == 1) begin
      nx = m_x; ny = m_y;
      if (m_dy == 1) begin
        if (m_y + 4 >= 752) begin ny = 752; m_dy = 0; end else ny = m_y + 4;
      end else begin
        if (m_y <= 4) begin ny = 0; m_dy = 1; end else ny = m_y - 4;
      end
      if (m_dx == 0) begin
        if (m_x - 4 <= 48 && m_x > 32 && m_y + 16 > pl && m_y < pl + 64) begin
          nx = 48; m_dx = 1; m_lhits++;
        end else if (m_x <= 4) begin
          nx = 0; ml = 1; m_mode = 2; m_left = 60; m_misses++;
        end else nx = m_x - 4;
      end else begin
        if (m_x + 20 >= 976 && m_x + 16 < 992 && m_y + 16 > pr && m_y < pr + 64) begin
          nx = 960; m_dx = 0;
        end else if (m_x >= 1004) begin
          nx = 1008; mr = 1; m_mode = 2; m_left = 60; m_misses++;
        end else nx = m_x + 4;
      end
      m_x = nx; m_y = ny;
    end else begin
      m_left--;
      if (m_left == 0) begin m_mode = 0; m_x = 504; m_y = 376; end
    end
  endtask

  // Compute expectations from the inputs now applied, clock once, compare.
  task automatic clk_step();
    logic [11:0] e_rgb;
    logic [25:0] e_pipe;
    int ml, mr;
    bit in_ball;
    ml = 0; mr = 0;
    if (rst) begin
      e_rgb = '0; e_pipe = '0;
      model_reset();
    end else begin
      in_ball = !hblnk_in && !vblnk_in &&
                int'(hcount_in) >= m_x && int'(hcount_in) < m_x + 16 &&
                int'(vcount_in) >= m_y && int'(vcount_in) < m_y + 16;
      e_rgb  = in_ball ? 12'hFFF : rgb_in;
      e_pipe = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      if (vblnk_in && m_vprev == 0)
        model_tick(int'(serve), int'(paddle_l_y), int'(paddle_r_y), ml, mr);
      m_vprev = int'(vblnk_in);
    end
    @(posedge pclk);
    #1;
    check("rgb_out", 32'(rgb_out), 32'(e_rgb));
    check("timing_pipe", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'(e_pipe));
    check("ball_x", 32'(ball_x), 32'(m_x));
    check("ball_y", 32'(ball_y), 32'(m_y));
    check("miss_l", 32'(miss_l), 32'(ml));
    check("miss_r", 32'(miss_r), 32'(mr));
  endtask

  task automatic rand_pix();
    int h, v;
    h = m_x + int'($urandom_range(0, 23)) - 4; if (h < 0) h = 0;
    v = m_y + int'($urandom_range(0, 23)) - 4; if (v < 0) v = 0;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    hblnk_in  = ($urandom_range(0, 7) == 0);
    rgb_in    = 12'($urandom);
  endtask

  task automatic frame(input int srv, input int pl, input int pr);
    serve = 1'(srv); paddle_l_y = 11'(pl); paddle_r_y = 11'(pr);
    for (int i = 0; i < 4; i++) begin rand_pix(); vblnk_in = 1'b0; clk_step(); end
    rand_pix(); vblnk_in = 1'b1; clk_step();
    rand_pix(); vblnk_in = 1'b1; clk_step();
  endtask

  initial begin
    int f;
    model_reset();
    rst = 1'b1; serve = 1'b0; paddle_l_y = '0; paddle_r_y = '0; vblnk_in = 1'b0;
    rand_pix();
    clk_step();
    clk_step();
    check("rst_ball_x", 32'(ball_x), 32'd504);
    check("rst_rgb", 32'(rgb_out), 32'd0);
    rst = 1'b0;

    frame(0, 0, 0);
    check("idle_hold_y", 32'(ball_y), 32'd376);
    hcount_in = 11'd504; vcount_in = 11'd376; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h123;
    clk_step();
    check("pix_ball", 32'(rgb_out), 32'hFFF);
    hcount_in = 11'd520;
    clk_step();
    check("pix_bg", 32'(rgb_out), 32'h123);

    frame(1, 0, 0);
    for (int i = 0; i < 3; i++) frame(0, 0, 0);
    check("serve3_x", 32'(ball_x), 32'd516);
    check("serve3_y", 32'(ball_y), 32'd388);

    // Both paddles track the ball until the left paddle returns it.
    for (f = 0; f < 2000 && m_lhits == 0; f++) frame(0, trk(m_y), trk(m_y));
    if (m_lhits == 0) check("left_hit_timeout", 32'(m_lhits), 32'd1);

    // Left paddle parked low: the ball eventually exits left and rests.
    for (f = 0; f < 3000 && !(m_misses > 0 && m_mode == 0); f++) frame(0, 700, trk(m_y));
    if (m_misses == 0 || m_mode != 0) check("left_miss_timeout", 32'(m_misses), 32'd1);

    // Random play with occasional serves and mostly-tracking paddles.
    for (int i = 0; i < 1200; i++) begin
      int pl, pr;
      pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 767)) : trk(m_y);
      pr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 767)) : trk(m_y);
      frame(($urandom_range(0, 3) == 0) ? 1 : 0, pl, pr);
    end

    // Drive play to the tick that would miss left, and reset on that tick.
    for (f = 0; f < 3000 && !(m_mode == 1 && m_dx == 0 && m_x <= 4); f++)
      frame((m_mode == 0) ? 1 : 0, 2000, trk(m_y));
    if (!(m_mode == 1 && m_dx == 0 && m_x <= 4)) check("pre_miss_timeout", 32'(m_x), 32'd4);
    for (int i = 0; i < 2; i++) begin rand_pix(); vblnk_in = 1'b0; clk_step(); end
    rand_pix(); vblnk_in = 1'b1; paddle_l_y = 11'd2000; rst = 1'b1;
    clk_step();
    check("rst_tick_miss_l", 32'(miss_l), 32'd0);
    check("rst_tick_x", 32'(ball_x), 32'd504);
    rst = 1'b0;
    frame(0, 0, 0);
    frame(1, 0, 0);
    frame(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
